pcileech_cfgspace_shadow_mf: RTL and testbench

PCILEECH_CFGSPACE_SHADOW_MF -- requirements
Module: pcileech_cfgspace_shadow_mf

---
 rtl/pcileech_cfgspace_shadow_mf.sv | 259 +++++++++++++++++++++++++
 tb/tb_pcileech_cfgspace_shadow_mf.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_cfgspace_shadow_mf.sv
// Multi-function PCIe configuration-space shadow: DATA / write-mask / RW1C-mask arrays
// shared between the PCIe cfg_ext port and a host port through one 2-cycle sequencer.
module pcileech_cfgspace_shadow_mf #(
    parameter int NUM_FUNC    = 2,
    parameter int DW_PER_FUNC = 1024,
    localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1,
    localparam int AW = $clog2(DW_PER_FUNC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_ext_read_received,
    input  logic             cfg_ext_write_received,
    input  logic [9:0]       cfg_ext_register_number,
    input  logic [3:0]       cfg_ext_function_number,
    input  logic [31:0]      cfg_ext_write_data,
    input  logic [3:0]       cfg_ext_write_byte_enable,
    output logic [31:0]      cfg_ext_read_data,
    output logic             cfg_ext_read_data_valid,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [1:0]       host_sel,
    input  logic [FW+AW-1:0] host_addr,
    input  logic [31:0]      host_wdata,
    output logic [31:0]      host_rdata,
    output logic             host_ack,
    output logic             cfg_overflow
);

    localparam int DEPTH = NUM_FUNC * DW_PER_FUNC;
    localparam int IW    = FW + AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CFG_RD  = 2'd1,
        CFG_WR  = 2'd2,
        HOST_OP = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   phase, phase_nxt;

    // NOTE: the arrays carry no reset; their contents must survive reset_n,
    // and a reset port would stop them mapping onto block RAM.
    logic [31:0] data_mem  [DEPTH];
    logic [31:0] wmask_mem [DEPTH];
    logic [31:0] w1c_mem   [DEPTH];

    // Incoming PCIe request decode
    logic          cfg_strobe;
    logic          cfg_ok;
    logic [IW-1:0] cfg_idx;
    logic [FW-1:0] host_func;
    logic          host_ok;

    assign cfg_strobe = cfg_ext_read_received | cfg_ext_write_received;
    assign cfg_ok     = (32'(cfg_ext_function_number) < 32'(NUM_FUNC)) &&
                        (32'(cfg_ext_register_number) < 32'(DW_PER_FUNC));
    assign cfg_idx    = {cfg_ext_function_number[FW-1:0], cfg_ext_register_number[AW-1:0]};
    assign host_func  = host_addr[IW-1:AW];
    assign host_ok    = (32'(host_func) < 32'(NUM_FUNC)) && (host_sel != 2'd3);

    // One-entry pending PCIe request
    logic          pend_valid;
    logic          pend_wr;
    logic [IW-1:0] pend_idx;
    logic          pend_ok;
    logic [31:0]   pend_wdata;
    logic [3:0]    pend_be;

    // Operation currently owning the arrays
    logic          op_wr;
    logic [IW-1:0] op_idx;
    logic          op_ok;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [1:0]    op_sel;

    logic          host_block;

    logic start_pend, start_new, start_host;
    logic pend_load, ovf_set;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        start_pend = 1'b0;
        start_new  = 1'b0;
        start_host = 1'b0;
        if (state == IDLE || phase) begin
            phase_nxt = 1'b0;
            if (pend_valid) begin
                start_pend = 1'b1;
                state_nxt  = pend_wr ? CFG_WR : CFG_RD;
            end else if (cfg_strobe) begin
                start_new  = 1'b1;
                state_nxt  = cfg_ext_write_received ? CFG_WR : CFG_RD;
            end else if (state == IDLE && host_req && !host_block) begin
                start_host = 1'b1;
                state_nxt  = HOST_OP;
            end else begin
                state_nxt  = IDLE;
            end
        end else begin
            phase_nxt = 1'b1;
        end
    end

    // A strobe not launched directly parks in the pending slot, or is lost if it is full.
    assign pend_load = cfg_strobe && !pend_valid && !start_new;
    assign ovf_set   = cfg_strobe && pend_valid;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    logic rd_phase;
    logic cfg_commit;
    logic host_commit;

    assign rd_phase    = (state != IDLE) && !phase;
    assign cfg_commit  = (state == CFG_WR) && phase && op_ok;
    assign host_commit = (state == HOST_OP) && phase && op_ok && op_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_idx   <= '0;
            pend_ok    <= 1'b0;
            pend_wdata <= '0;
            pend_be    <= '0;
            op_wr      <= 1'b0;
            op_idx     <= '0;
            op_ok      <= 1'b0;
            op_wdata   <= '0;
            op_be      <= '0;
            op_sel     <= '0;
        end else begin
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_wr    <= cfg_ext_write_received;
                pend_idx   <= cfg_idx;
                pend_ok    <= cfg_ok;
                pend_wdata <= cfg_ext_write_data;
                pend_be    <= cfg_ext_write_byte_enable;
            end else if (start_pend) begin
                pend_valid <= 1'b0;
            end

            if (start_pend) begin
                op_wr    <= pend_wr;
                op_idx   <= pend_idx;
                op_ok    <= pend_ok;
                op_wdata <= pend_wdata;
                op_be    <= pend_be;
                op_sel   <= 2'd0;
            end else if (start_new) begin
                op_wr    <= cfg_ext_write_received;
                op_idx   <= cfg_idx;
                op_ok    <= cfg_ok;
                op_wdata <= cfg_ext_write_data;
                op_be    <= cfg_ext_write_byte_enable;
                op_sel   <= 2'd0;
            end else if (start_host) begin
                op_wr    <= host_we;
                op_idx   <= host_addr;
                op_ok    <= host_ok;
                op_wdata <= host_wdata;
                op_be    <= 4'hF;
                op_sel   <= host_sel;
            end
        end
    end

    // First cycle of every operation: snapshot all three arrays at the target word.
    logic [31:0] rd_data, rd_wmask, rd_w1c;

    always_ff @(posedge clk) begin
        if (rd_phase) begin
            rd_data  <= data_mem[op_idx];
            rd_wmask <= wmask_mem[op_idx];
            rd_w1c   <= w1c_mem[op_idx];
        end
    end

    logic [31:0] be_mask;
    logic [31:0] wr_bits;
    logic [31:0] commit_data;

    assign be_mask     = {{8{op_be[3]}}, {8{op_be[2]}}, {8{op_be[1]}}, {8{op_be[0]}}};
    assign wr_bits     = op_wdata & be_mask;
    // RW1C bits clear where a 1 is written; other bits take new data only where writable.
    assign commit_data = (rd_w1c & rd_data & ~wr_bits) |
                         (~rd_w1c & ((rd_data & ~(rd_wmask & be_mask)) | (wr_bits & rd_wmask)));

    always_ff @(posedge clk) begin
        if (cfg_commit) begin
            data_mem[op_idx] <= commit_data;
        end else if (host_commit && op_sel == 2'd0) begin
            data_mem[op_idx] <= op_wdata;
        end
        if (host_commit && op_sel == 2'd1) begin
            wmask_mem[op_idx] <= op_wdata;
        end
        if (host_commit && op_sel == 2'd2) begin
            w1c_mem[op_idx] <= op_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_ext_read_data       <= '0;
            cfg_ext_read_data_valid <= 1'b0;
            host_rdata              <= '0;
            host_ack                <= 1'b0;
            cfg_overflow            <= 1'b0;
            host_block              <= 1'b0;
        end else begin
            cfg_ext_read_data_valid <= (state == CFG_RD) && phase;
            if ((state == CFG_RD) && phase) begin
                cfg_ext_read_data <= op_ok ? rd_data : 32'h0;
            end

            host_ack <= (state == HOST_OP) && !phase;
            if ((state == HOST_OP) && !phase) begin
                if (!op_ok) begin
                    host_rdata <= 32'h0;
                end else begin
                    unique case (op_sel)
                        2'd0:    host_rdata <= data_mem[op_idx];
                        2'd1:    host_rdata <= wmask_mem[op_idx];
                        2'd2:    host_rdata <= w1c_mem[op_idx];
                        default: host_rdata <= 32'h0;
                    endcase
                end
            end

            if (ovf_set) begin
                cfg_overflow <= 1'b1;
            end

            // A request already acknowledged must drop before another host op can start.
            if ((state == HOST_OP) && !phase) begin
                host_block <= 1'b1;
            end else if (!host_req) begin
                host_block <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_cfgspace_shadow_mf.sv
// Directed bench for pcileech_cfgspace_shadow_mf: vector table for single transactions,
// hand-written sequences for back-to-back, overflow, host starvation and reset abort.
module tb_pcileech_cfgspace_shadow_mf;

    localparam int NUM_FUNC    = 2;
    localparam int DW_PER_FUNC = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_ext_read_received = 1'b0;
    logic        cfg_ext_write_received = 1'b0;
    logic [9:0]  cfg_ext_register_number = '0;
    logic [3:0]  cfg_ext_function_number = '0;
    logic [31:0] cfg_ext_write_data = '0;
    logic [3:0]  cfg_ext_write_byte_enable = '0;
    logic [31:0] cfg_ext_read_data;
    logic        cfg_ext_read_data_valid;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [1:0]  host_sel = '0;
    logic [10:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_ack;
    logic        cfg_overflow;

    pcileech_cfgspace_shadow_mf #(
        .NUM_FUNC   (NUM_FUNC),
        .DW_PER_FUNC(DW_PER_FUNC)
    ) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .cfg_ext_read_received    (cfg_ext_read_received),
        .cfg_ext_write_received   (cfg_ext_write_received),
        .cfg_ext_register_number  (cfg_ext_register_number),
        .cfg_ext_function_number  (cfg_ext_function_number),
        .cfg_ext_write_data       (cfg_ext_write_data),
        .cfg_ext_write_byte_enable(cfg_ext_write_byte_enable),
        .cfg_ext_read_data        (cfg_ext_read_data),
        .cfg_ext_read_data_valid  (cfg_ext_read_data_valid),
        .host_req                 (host_req),
        .host_we                  (host_we),
        .host_sel                 (host_sel),
        .host_addr                (host_addr),
        .host_wdata               (host_wdata),
        .host_rdata               (host_rdata),
        .host_ack                 (host_ack),
        .cfg_overflow             (cfg_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    typedef enum logic [1:0] {HW, HR, PW, PR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [1:0]  sel;
        logic [3:0]  f;
        logic [9:0]  r;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] expv;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic set_cfg(input logic [3:0] f, input logic [9:0] r,
                           input logic [31:0] d, input logic [3:0] be);
        cfg_ext_function_number   = f;
        cfg_ext_register_number   = r;
        cfg_ext_write_data        = d;
        cfg_ext_write_byte_enable = be;
    endtask

    task automatic host_op(input logic we, input logic [1:0] sel, input logic [3:0] f,
                           input logic [9:0] r, input logic [31:0] wd,
                           output logic [31:0] rd, output logic ok);
        host_we    = we;
        host_sel   = sel;
        host_addr  = {f[0], r};
        host_wdata = wd;
        host_req   = 1'b1;
        ok = 1'b0;
        rd = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk); #1;
            if (host_ack) begin
                ok = 1'b1;
                rd = host_rdata;
            end
        end
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pcie_read(input logic [3:0] f, input logic [9:0] r,
                             output logic [31:0] data, output int lat);
        set_cfg(f, r, 32'h0, 4'h0);
        cfg_ext_read_received = 1'b1;
        @(posedge clk); #1;
        cfg_ext_read_received = 1'b0;
        lat  = -1;
        data = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (cfg_ext_read_data_valid && lat < 0) begin
                lat  = k;
                data = cfg_ext_read_data;
            end
        end
    endtask

    task automatic pcie_write(input logic [3:0] f, input logic [9:0] r,
                              input logic [31:0] d, input logic [3:0] be, output int nvalid);
        set_cfg(f, r, d, be);
        cfg_ext_write_received = 1'b1;
        @(posedge clk); #1;
        cfg_ext_write_received = 1'b0;
        nvalid = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (cfg_ext_read_data_valid) nvalid++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        ok;
        int          lat;
        int          nv;
        int          first_v;
        int          second_v;
        int          first_ack;
        logic [31:0] dv1;
        logic [31:0] dv2;

        vecs[0]  = '{HW, 2'd0, 4'd0, 10'd1,    32'h12345678, 4'hF, 32'h0};
        vecs[1]  = '{HW, 2'd1, 4'd0, 10'd1,    32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[2]  = '{PR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h12345678};
        vecs[3]  = '{HW, 2'd1, 4'd0, 10'd1,    32'h0000FFFF, 4'hF, 32'h0};
        vecs[4]  = '{PW, 2'd0, 4'd0, 10'd1,    32'h87654321, 4'hF, 32'h0};
        vecs[5]  = '{HR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h12344321};
        vecs[6]  = '{PW, 2'd0, 4'd0, 10'd1,    32'hAABBCCDD, 4'h5, 32'h0};
        vecs[7]  = '{PR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h123443DD};
        vecs[8]  = '{HW, 2'd2, 4'd0, 10'd1,    32'h000000FF, 4'hF, 32'h0};
        vecs[9]  = '{HW, 2'd0, 4'd0, 10'd1,    32'h000000A5, 4'hF, 32'h0};
        vecs[10] = '{PW, 2'd0, 4'd0, 10'd1,    32'h00000021, 4'h1, 32'h0};
        vecs[11] = '{PR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h00000084};
        vecs[12] = '{PR, 2'd0, 4'd2, 10'd1,    32'h0,        4'h0, 32'h00000000};
        vecs[13] = '{PW, 2'd0, 4'd2, 10'd1,    32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[14] = '{HR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h00000084};
        vecs[15] = '{HR, 2'd1, 4'd0, 10'd1,    32'h0,        4'h0, 32'h0000FFFF};
        vecs[16] = '{HR, 2'd2, 4'd0, 10'd1,    32'h0,        4'h0, 32'h000000FF};
        vecs[17] = '{HW, 2'd3, 4'd0, 10'd1,    32'hDEADBEEF, 4'hF, 32'h0};
        vecs[18] = '{HR, 2'd3, 4'd0, 10'd1,    32'h0,        4'h0, 32'h00000000};
        vecs[19] = '{HR, 2'd0, 4'd0, 10'd1,    32'h0,        4'h0, 32'h00000084};
        vecs[20] = '{HW, 2'd0, 4'd1, 10'd5,    32'hCAFEF00D, 4'hF, 32'h0};
        vecs[21] = '{HW, 2'd0, 4'd1, 10'd1023, 32'h0BADC0DE, 4'hF, 32'h0};
        vecs[22] = '{PR, 2'd0, 4'd1, 10'd5,    32'h0,        4'h0, 32'hCAFEF00D};
        vecs[23] = '{PR, 2'd0, 4'd1, 10'd1023, 32'h0,        4'h0, 32'h0BADC0DE};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata",    cfg_ext_read_data, 32'h0);
        check("rst_valid",    {31'b0, cfg_ext_read_data_valid}, 32'h0);
        check("rst_hrdata",   host_rdata, 32'h0);
        check("rst_hack",     {31'b0, host_ack}, 32'h0);
        check("rst_overflow", {31'b0, cfg_overflow}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            case (vecs[i].kind)
                HW: begin
                    host_op(1'b1, vecs[i].sel, vecs[i].f, vecs[i].r, vecs[i].data, rd, ok);
                    check($sformatf("v%0d hw_ack", i), {31'b0, ok}, 32'h1);
                end
                HR: begin
                    host_op(1'b0, vecs[i].sel, vecs[i].f, vecs[i].r, 32'h0, rd, ok);
                    check($sformatf("v%0d hr_ack", i), {31'b0, ok}, 32'h1);
                    check($sformatf("v%0d hr_data", i), rd, vecs[i].expv);
                end
                PW: begin
                    pcie_write(vecs[i].f, vecs[i].r, vecs[i].data, vecs[i].be, nv);
                    check($sformatf("v%0d pw_no_valid", i), 32'(nv), 32'h0);
                end
                default: begin
                    pcie_read(vecs[i].f, vecs[i].r, rd, lat);
                    check($sformatf("v%0d pr_latency", i), 32'(lat), 32'd2);
                    check($sformatf("v%0d pr_data", i), rd, vecs[i].expv);
                end
            endcase
        end

        // Write then read of the same word back to back; write and read strobes together act as a write
        host_op(1'b1, 2'd1, 4'd0, 10'd3, 32'hFFFFFFFF, rd, ok);
        host_op(1'b1, 2'd2, 4'd0, 10'd3, 32'h00000000, rd, ok);
        host_op(1'b1, 2'd0, 4'd0, 10'd3, 32'h11111111, rd, ok);
        nv = 0; first_v = -1; dv1 = '0;
        for (int k = 0; k < 10; k++) begin
            cfg_ext_read_received  = (k == 0) || (k == 1);
            cfg_ext_write_received = (k == 0);
            set_cfg(4'd0, 10'd3, 32'h5A5A5A5A, 4'hF);
            @(posedge clk); #1;
            cfg_ext_read_received  = 1'b0;
            cfg_ext_write_received = 1'b0;
            if (cfg_ext_read_data_valid) begin
                nv++;
                if (first_v < 0) begin
                    first_v = k;
                    dv1 = cfg_ext_read_data;
                end
            end
        end
        check("wr_rd_valid_count", 32'(nv), 32'd1);
        check("wr_rd_valid_edge",  32'(first_v), 32'd4);
        check("wr_rd_fresh_data",  dv1, 32'h5A5A5A5A);
        check("wr_rd_no_overflow", {31'b0, cfg_overflow}, 32'h0);

        // Three strobes on consecutive cycles: two served, third dropped
        nv = 0; first_v = -1; second_v = -1; dv1 = '0; dv2 = '0;
        for (int k = 0; k < 10; k++) begin
            cfg_ext_read_received = (k < 3);
            case (k)
                0:       set_cfg(4'd0, 10'd1,    32'h0, 4'h0);
                1:       set_cfg(4'd1, 10'd5,    32'h0, 4'h0);
                default: set_cfg(4'd1, 10'd1023, 32'h0, 4'h0);
            endcase
            @(posedge clk); #1;
            cfg_ext_read_received = 1'b0;
            if (cfg_ext_read_data_valid) begin
                nv++;
                if (first_v < 0) begin
                    first_v = k;
                    dv1 = cfg_ext_read_data;
                end else if (second_v < 0) begin
                    second_v = k;
                    dv2 = cfg_ext_read_data;
                end
            end
        end
        check("ovf_valid_count", 32'(nv), 32'd2);
        check("ovf_first_edge",  32'(first_v), 32'd2);
        check("ovf_second_edge", 32'(second_v), 32'd4);
        check("ovf_first_data",  dv1, 32'h00000084);
        check("ovf_second_data", dv2, 32'hCAFEF00D);
        check("ovf_flag",        {31'b0, cfg_overflow}, 32'h1);

        // Host read held while PCIe reads keep arriving every other cycle
        host_we   = 1'b0;
        host_sel  = 2'd0;
        host_addr = {1'b1, 10'd5};
        host_req  = 1'b1;
        nv = 0; first_ack = -1; rd = '0;
        for (int k = 0; k < 30; k++) begin
            cfg_ext_read_received = (k <= 8) && (k % 2 == 0);
            set_cfg(4'd0, 10'd1, 32'h0, 4'h0);
            if (first_ack >= 0) host_req = 1'b0;
            @(posedge clk); #1;
            cfg_ext_read_received = 1'b0;
            if (cfg_ext_read_data_valid) nv++;
            if (host_ack && first_ack < 0) begin
                first_ack = k;
                rd = host_rdata;
            end
        end
        host_req = 1'b0;
        check("starve_pcie_valids", 32'(nv), 32'd5);
        check("starve_ack_edge",    32'(first_ack), 32'd12);
        check("starve_host_data",   rd, 32'hCAFEF00D);

        // Reset in the second cycle of a PCIe write
        set_cfg(4'd0, 10'd3, 32'h22222222, 4'hF);
        cfg_ext_write_received = 1'b1;
        @(posedge clk); #1;
        cfg_ext_write_received = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_rdata",    cfg_ext_read_data, 32'h0);
        check("abort_valid",    {31'b0, cfg_ext_read_data_valid}, 32'h0);
        check("abort_hrdata",   host_rdata, 32'h0);
        check("abort_hack",     {31'b0, host_ack}, 32'h0);
        check("abort_overflow", {31'b0, cfg_overflow}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        host_op(1'b0, 2'd0, 4'd0, 10'd3, 32'h0, rd, ok);
        check("abort_word_kept", rd, 32'h5A5A5A5A);
        host_op(1'b0, 2'd0, 4'd0, 10'd1, 32'h0, rd, ok);
        check("abort_array_kept", rd, 32'h00000084);
        pcie_read(4'd0, 10'd3, rd, lat);
        check("post_reset_latency", 32'(lat), 32'd2);
        check("post_reset_data",    rd, 32'h5A5A5A5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
